// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a single-ported RAM between an instruction cache and a
// data cache. Dcache wins simultaneous requests from IDLE unless the icache has
// been passed over STARVE_LIMIT times in a row, in which case icache is forced.
// Grants are never preempted; each grant ends on one ACCESS or when its owner
// withdraws the request.
//
// Ports:
//   CLK, nRST                     clock (rising edge), async active-low reset
//   iREN, iaddr                   icache read request and word address
//   iwait, iload                  icache stall (1 = not done) and read data
//   dREN, dWEN, daddr, dstore     dcache read/write request, address, write data
//   dwait, dload                  dcache stall (1 = not done) and read data
//   ramREN, ramWEN                RAM read/write enables
//   ramaddr, ramstore             RAM address and write data
//   ramload, ramstate             RAM read data and status (FREE/BUSY/ACCESS/ERROR)
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate
);

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [2:0] LIMIT      = 3'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE,
      IGRANT,
      DGRANT
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] starve_q, starve_d;
   logic       d_req;

   assign d_req = dREN | dWEN;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         starve_q <= 3'd0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // Outputs are decoded from the registered state, so an async reset forces
   // them to their idle values immediately.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = 32'd0;
      dload    = 32'd0;

      case (state_q)
         IDLE: begin
            if (iREN && d_req) begin
               state_d = (starve_q == LIMIT) ? IGRANT : DGRANT;
            end else if (d_req) begin
               state_d = DGRANT;
            end else if (iREN) begin
               state_d = IGRANT;
            end
         end

         IGRANT: begin
            iload = ramload;
            if (iREN) begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (ramstate == RAM_ACCESS) begin
                  iwait    = 1'b0;
                  state_d  = IDLE;
                  starve_d = 3'd0;
               end
            end else begin
               // Owner withdrew: release the RAM without a completion.
               state_d = IDLE;
            end
         end

         DGRANT: begin
            dload = ramload;
            if (d_req) begin
               ramWEN   = dWEN;
               ramREN   = dREN & ~dWEN;
               ramaddr  = daddr;
               ramstore = dstore;
               if (ramstate == RAM_ACCESS) begin
                  dwait   = 1'b0;
                  state_d = IDLE;
                  if (!iREN) begin
                     starve_d = 3'd0;
                  end else if (starve_q < LIMIT) begin
                     starve_d = starve_q + 3'd1;
                  end
               end
            end else begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive dcache grants allowed while iREN is pending before icache is forced.
REQ-002 Reset is nRST, asynchronous, active-low; clock is CLK.
REQ-003 CLK  in  1  system clock, rising-edge.
REQ-004 nRST  in  1  asynchronous active-low reset.
REQ-005 iREN  in  1  icache read request.
REQ-006 iaddr  in  32  icache word address.
REQ-007 iwait  out  1  high = icache request not yet complete.
REQ-008 iload  out  32  icache read data.
REQ-009 dREN  in  1  dcache read request.
REQ-010 dWEN  in  1  dcache write request.
REQ-011 daddr  in  32  dcache word address.
REQ-012 dstore  in  32  dcache write data.
REQ-013 dwait  out  1  high = dcache request not yet complete.
REQ-014 dload  out  32  dcache read data.
REQ-015 ramREN  out  1  RAM read enable.
REQ-016 ramWEN  out  1  RAM write enable.
REQ-017 ramaddr  out  32  RAM address.
REQ-018 ramstore  out  32  RAM write data.
REQ-019 ramload  in  32  RAM read data.
REQ-020 ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Function
REQ-021 FSM states SHALL be IDLE, IGRANT and DGRANT, held in a registered state.
REQ-022 IDLE with no request SHALL stay in IDLE, with all ram outputs 0 and both waits 1.
REQ-023 IDLE with only iREN high SHALL go to IGRANT next cycle.
REQ-024 IDLE with only dREN or dWEN high SHALL go to DGRANT next cycle.
REQ-025 IDLE with both caches requesting SHALL go to DGRANT, unless starve_cnt equals STARVE_LIMIT, in which case it SHALL go to IGRANT.
REQ-026 In IGRANT: ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0, and iload=ramload.
REQ-027 In DGRANT: ramWEN=dWEN, ramREN=dREN and not dWEN (write wins), ramaddr=daddr, ramstore=dstore, and dload=ramload.
REQ-028 iwait SHALL be 0 only in a cycle where state=IGRANT and ramstate=ACCESS; dwait likewise for DGRANT.
REQ-029 Grant state with ramstate=ACCESS SHALL return to IDLE next cycle, giving one completion per grant.
REQ-030 The minimum request-to-completion latency SHALL be 2 cycles: IDLE, then the grant state with ACCESS.
REQ-031 ramstate FREE, BUSY or ERROR SHALL hold the grant, keep wait=1 and keep ram outputs driven; ERROR is retried like BUSY.
REQ-032 Grant state whose owner drops all requests before ACCESS SHALL drive ram outputs 0 that cycle and go to IDLE next cycle, with no completion counted.
REQ-033 A grant SHALL never be preempted; a new request from the other cache waits until the current grant returns to IDLE.
REQ-034 In all other states iload and dload SHALL be 0.
REQ-035 starve_cnt is a 3-bit register.
REQ-036 On DGRANT completion with iREN high, starve_cnt SHALL increment, saturating at STARVE_LIMIT.
REQ-037 On DGRANT completion with iREN low, starve_cnt SHALL clear.
REQ-038 On IGRANT completion, starve_cnt SHALL clear.

Reset
REQ-039 nRST low SHALL immediately force: state=IDLE, starve_cnt=0, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
REQ-040 Reset asserted mid-grant SHALL abandon the transaction with no completion pulse.
REQ-041 After release, the first grant SHALL be evaluated from IDLE on the next rising edge.

Verification
REQ-042 iREN=1, iaddr=0x40, ramload=0xDEADBEEF, ramstate=ACCESS the cycle after the request -> cycle1 ramREN=1, ramaddr=0x40; iwait=0 with iload=0xDEADBEEF for exactly 1 cycle; IDLE next.
REQ-043 iREN=1 and dREN=1 together from IDLE, RAM gives ACCESS after 2 BUSY cycles -> DGRANT first, dwait low once; IGRANT next, iwait low once.
REQ-044 dWEN=1, dREN=1, daddr=0x80, dstore=0x1234 -> ramWEN=1, ramREN=0, ramstore=0x1234 until ACCESS.
REQ-045 iREN held high while the dcache issues back-to-back requests -> exactly 4 DGRANT completions, then IGRANT is forced; starve_cnt returns to 0 after the I completion.
REQ-046 ramstate=ERROR for 3 cycles then ACCESS in DGRANT -> dwait stays 1 throughout ERROR and the grant holds; single completion on ACCESS.
REQ-047 nRST pulsed low in DGRANT during BUSY -> outputs immediately at reset values; no dwait=0 pulse; FSM restarts from IDLE.
